fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end. It reads a fixed 2-cycle-latency
// instruction memory, tracks in-flight reads, and feeds decode through a
// credit-protected circular buffer with registered head outputs.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN. When it is defined, a
// misaligned redirect moves the unit to a sticky FAULT state.
module fetch_unit #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          BUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:2] mem_raddr,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [63:0] out_pc,
  output logic        fault
);

  localparam int PW = $clog2(BUF_DEPTH);

  typedef enum logic {RUN, FAULT} state_t;

  state_t      state;
  logic [63:0] pc;

  // In-flight read tracking: stage 1 = address just issued, stage 2 = data arriving.
  logic        vld_p1, vld_p2;
  logic [63:0] pc_p1, pc_p2;

  logic [31:0] buf_inst [BUF_DEPTH];
  logic [63:0] buf_pc   [BUF_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count;

  logic          redir, misalign, issue, push, pop;
  logic [PW:0]   inflight, count_after_pop, count_next;
  logic [PW-1:0] rd_next;
  logic          head_from_push;
  logic [31:0]   head_inst;
  logic [63:0]   head_pc;
  logic [63:0]   redir_target;
  logic          unused_redirect_lsb;

  assign mem_raddr = pc[63:2];

  // Issue, buffer bookkeeping and next buffer-head selection.
  always_comb begin
    redir    = redirect_valid && (state == RUN);
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign = redir && (redirect_pc[1:0] != 2'b00);
`else
    misalign = 1'b0;
`endif
    redir_target    = {redirect_pc[63:2], 2'b00};
    inflight        = (PW+1)'(vld_p1) + (PW+1)'(vld_p2);
    issue           = (state == RUN) && !redir && ((count + inflight) < (PW+1)'(BUF_DEPTH));
    push            = vld_p2;
    pop             = out_valid && out_ready;
    rd_next         = rd_ptr + PW'(pop);
    count_after_pop = count - (PW+1)'(pop);
    count_next      = count_after_pop + (PW+1)'(push);
    head_from_push  = push && (count_after_pop == '0);
    head_inst       = head_from_push ? mem_rdata : buf_inst[rd_next];
    head_pc         = head_from_push ? pc_p2     : buf_pc[rd_next];
  end

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Buffer storage: data only, pointers and count carry the validity.
  always_ff @(posedge clk) begin
    if (push && !redir) begin
      buf_inst[wr_ptr] <= mem_rdata;
      buf_pc[wr_ptr]   <= pc_p2;
    end
  end

  // In-flight pc pipeline (data, follows the valid bits).
  always_ff @(posedge clk) begin
    pc_p1 <= pc;
    pc_p2 <= pc_p1;
  end

  // Control: state, fetch pc, in-flight valids, pointers and registered head outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      pc        <= RESET_PC;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_inst  <= 32'h0;
      out_pc    <= 64'h0;
    end else if (redir) begin
      pc        <= redir_target;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      if (misalign) state <= FAULT;
    end else begin
      vld_p1    <= issue;
      vld_p2    <= vld_p1;
      if (issue) pc <= pc + 64'd4;
      rd_ptr    <= rd_next;
      wr_ptr    <= wr_ptr + PW'(push);
      count     <= count_next;
      out_valid <= (count_next != '0);
      out_inst  <= head_inst;
      out_pc    <= head_pc;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // Sticky fault flag, raised the cycle after a misaligned redirect.
  always_ff @(posedge clk) begin
    if (reset)         fault <= 1'b0;
    else if (misalign) fault <= 1'b1;
  end
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit. Memory word i holds 32'h100+i
// and answers two cycles after its address. Cycle 0 is the first cycle after
// reset deasserts; inputs are driven and outputs sampled 1ns after each edge.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:2] mem_raddr;
  logic [31:0] mem_rdata;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [63:0] out_pc;
  logic        fault;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] mem_d1;

  fetch_unit dut (
    .clk(clk), .reset(reset), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .fault(fault)
  );

  always #5 clk = ~clk;

  // Two-cycle memory model: word i = 32'h100 + i.
  always @(posedge clk) begin
    mem_d1    <= 32'h100 + mem_raddr[33:2];
    mem_rdata <= mem_d1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start(input logic ready);
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 64'h0; out_ready = ready;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    start(1'b0);
    for (int k = 0; k < 6; k++) tick();
    reset = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    checks++; if (out_inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %h want 0", out_inst); end
    checks++; if (out_pc !== 64'h0) begin errors++; $display("FAIL reset_pc got %h want 0", out_pc); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %0b want 0", fault); end
    checks++; if (mem_raddr !== 62'h0) begin errors++; $display("FAIL reset_raddr got %h want 0", mem_raddr); end
  endtask

  task automatic test_stream();
    logic [63:0] epc;
    start(1'b1);
    checks++; if (mem_raddr !== 62'h0) begin errors++; $display("FAIL stream_first_issue got %h want 0", mem_raddr); end
    for (int k = 0; k < 14; k++) begin
      epc = 64'(4 * (k - 3));
      if (k < 3) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_early c%0d valid got %0b want 0", k, out_valid); end
      end else begin
        checks++;
        if (out_valid !== 1'b1 || out_pc !== epc || out_inst !== 32'(32'h100 + k - 3)) begin
          errors++;
          $display("FAIL stream c%0d got v%0b pc %h inst %h want v1 pc %h inst %h",
                   k, out_valid, out_pc, out_inst, epc, 32'(32'h100 + k - 3));
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] epc;
    start(1'b0);
    for (int k = 0; k < 13; k++) begin
      if (k >= 3) begin
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 64'h0 || out_inst !== 32'h100) begin
          errors++;
          $display("FAIL stall_hold c%0d got v%0b pc %h inst %h want v1 pc 0 inst 100", k, out_valid, out_pc, out_inst);
        end
      end
      if (k == 12) begin
        checks++; if (mem_raddr !== 62'h4) begin errors++; $display("FAIL stall_issues got raddr %h want 4", mem_raddr); end
      end
      tick();
    end
    out_ready = 1'b1;
    for (int k = 13; k < 25; k++) begin
      epc = 64'(4 * (k - 13));
      checks++;
      if (out_valid !== 1'b1 || out_pc !== epc || out_inst !== 32'(32'h100 + k - 13)) begin
        errors++;
        $display("FAIL drain c%0d got v%0b pc %h inst %h want v1 pc %h inst %h",
                 k, out_valid, out_pc, out_inst, epc, 32'(32'h100 + k - 13));
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    start(1'b1);
    for (int k = 0; k < 13; k++) begin
      redirect_valid = (k == 6);
      redirect_pc    = (k == 6) ? 64'h40 : 64'h0;
      if (k >= 7 && k <= 9) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_flush c%0d valid got %0b want 0", k, out_valid); end
      end
      if (k >= 10) begin
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 64'(64'h40 + 4 * (k - 10)) || out_inst !== 32'(32'h110 + k - 10)) begin
          errors++;
          $display("FAIL redir_target c%0d got v%0b pc %h inst %h want pc %h", k, out_valid, out_pc, out_inst, 64'(64'h40 + 4 * (k - 10)));
        end
      end
      tick();
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_full_redirect();
    start(1'b0);
    for (int k = 0; k < 18; k++) begin
      out_ready      = (k >= 12);
      redirect_valid = (k == 12);
      redirect_pc    = (k == 12) ? 64'h80 : 64'h0;
      if (k == 12) begin
        checks++; if (out_valid !== 1'b1 || out_pc !== 64'h0) begin errors++; $display("FAIL full_head got v%0b pc %h want v1 pc 0", out_valid, out_pc); end
      end
      if (k >= 13 && k <= 15) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_discard c%0d valid got %0b want 0 pc %h", k, out_valid, out_pc); end
      end
      if (k == 16) begin
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 64'h80 || out_inst !== 32'h120) begin
          errors++; $display("FAIL full_target got v%0b pc %h inst %h want v1 pc 80 inst 120", out_valid, out_pc, out_inst);
        end
      end
      tick();
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_misalign();
    start(1'b1);
    for (int k = 0; k < 15; k++) begin
      redirect_valid = (k == 6) || (k == 9);
      redirect_pc    = (k == 6) ? 64'h42 : 64'h100;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (k >= 7) begin
        checks++;
        if (fault !== 1'b1 || out_valid !== 1'b0) begin
          errors++; $display("FAIL trap c%0d got fault %0b valid %0b want fault 1 valid 0", k, fault, out_valid);
        end
      end
      if (k == 14) begin
        checks++; if (mem_raddr !== 62'h10) begin errors++; $display("FAIL trap_pc_frozen got raddr %h want 10", mem_raddr); end
      end
`else
      if (k == 9) redirect_valid = 1'b0;
      if (k >= 7) begin
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL nofault c%0d got %0b want 0", k, fault); end
      end
      if (k == 10) begin
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 64'h40 || out_inst !== 32'h110) begin
          errors++; $display("FAIL align_target got v%0b pc %h inst %h want v1 pc 40 inst 110", out_valid, out_pc, out_inst);
        end
      end
`endif
      tick();
    end
    redirect_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL fault_cleared got %0b want 0", fault); end
  endtask

  task automatic test_reset_midstream();
    start(1'b1);
    for (int k = 0; k < 15; k++) begin
      reset = (k == 8);
      if (k >= 9 && k <= 11) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_flush c%0d valid got %0b want 0", k, out_valid); end
      end
      if (k == 12) begin
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 64'h0 || out_inst !== 32'h100) begin
          errors++; $display("FAIL midreset_restart got v%0b pc %h inst %h want v1 pc 0 inst 100", out_valid, out_pc, out_inst);
        end
      end
      if (k == 13) begin
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 64'h4 || out_inst !== 32'h101) begin
          errors++; $display("FAIL midreset_next got v%0b pc %h inst %h want v1 pc 4 inst 101", out_valid, out_pc, out_inst);
        end
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 64'h0; out_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_full_redirect();
    test_misalign();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
